// File: rtl/pc_sequencer_if.sv
// Fetch-stage next-PC bus between the pipeline/pc_register side (master) and pc_sequencer (slave).
interface pc_sequencer_if #(parameter int CNT_W = 6);
  logic [31:0]      pc_current;
  logic             hazard_stall;
  logic             mdu_start;
  logic [CNT_W-1:0] mdu_cycles;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             jump_valid;
  logic [31:0]      jump_target;
  logic             exc_req;
  logic             eret_req;
  logic [31:0]      pc_next;
  logic             pc_enable;
  logic             pc_pause;
  logic [31:0]      epc;
  logic             flush;

  modport master (
    output pc_current, hazard_stall, mdu_start, mdu_cycles, branch_taken, branch_target,
           jump_valid, jump_target, exc_req, eret_req,
    input  pc_next, pc_enable, pc_pause, epc, flush
  );

  modport slave (
    input  pc_current, hazard_stall, mdu_start, mdu_cycles, branch_taken, branch_target,
           jump_valid, jump_target, exc_req, eret_req,
    output pc_next, pc_enable, pc_pause, epc, flush
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller for the MIPS fetch stage: sequential/branch/jump/exception/eret arbitration,
// stall hold with buffered redirects. Define DELAY_SLOT_EN for branch-delay-slot semantics.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h00400000,
  parameter logic [31:0] EXC_VECTOR = 32'h00400004,
  parameter int          CNT_W      = 6
) (
  input logic           clock,
  input logic           reset,
  pc_sequencer_if.slave s
);

`ifdef DELAY_SLOT_EN
  typedef enum logic [1:0] {RUN, STALL, DELAY} state_t;
  localparam bit DS = 1'b1;
`else
  typedef enum logic [1:0] {RUN, STALL} state_t;
  localparam bit DS = 1'b0;
`endif

  state_t           state;
  logic             en_r;
  logic [31:0]      epc_r;
  logic [CNT_W-1:0] mdu_cnt;
  logic             pend_valid;
  logic [31:0]      pend_target;
  logic [1:0]       pend_prio;

  logic        stall, in_delay, redir, latch_pend;
  logic [1:0]  redir_prio;
  logic [31:0] redir_tgt, pc_seq, nxt;
  logic        pause, fl;

`ifdef DELAY_SLOT_EN
  assign in_delay = (state == DELAY);
`else
  assign in_delay = 1'b0;
`endif

  assign pc_seq = s.pc_current + 32'd4;
  assign stall  = s.hazard_stall | (mdu_cnt != '0) | (s.mdu_start & (s.mdu_cycles != '0));

  // Highest-priority non-exception redirect this cycle; prio lets a buffered one be overwritten.
  always_comb begin
    redir      = 1'b0;
    redir_prio = 2'd0;
    redir_tgt  = '0;
    if (s.eret_req) begin
      redir = 1'b1; redir_prio = 2'd3; redir_tgt = epc_r;
    end else if (s.jump_valid) begin
      redir = 1'b1; redir_prio = 2'd2; redir_tgt = s.jump_target;
    end else if (s.branch_taken) begin
      redir = 1'b1; redir_prio = 2'd1; redir_tgt = s.branch_target;
    end
  end

  assign latch_pend = redir & ~in_delay & (~pend_valid | (redir_prio >= pend_prio));

  always_comb begin
    nxt   = pc_seq;
    pause = stall;
    fl    = 1'b0;
    if (!en_r) begin
      nxt   = RESET_PC;
      pause = 1'b0;
    end else if (s.exc_req) begin
      nxt   = EXC_VECTOR;
      pause = 1'b0;
      fl    = 1'b1;
    end else if (stall) begin
      nxt = s.pc_current;
    end else if (in_delay) begin
      nxt = pend_target;
    end else if (redir) begin
      // With delay slots, jump/branch first fetch the slot; the target follows from DELAY.
      if (DS && !s.eret_req) begin
        nxt = pc_seq;
      end else begin
        nxt = redir_tgt;
        fl  = 1'b1;
      end
    end else if (pend_valid) begin
      nxt = pend_target;
      fl  = ~DS;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      en_r        <= 1'b0;
      epc_r       <= RESET_PC;
      mdu_cnt     <= '0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      pend_prio   <= '0;
    end else begin
      en_r <= 1'b1;
      if (en_r) begin
        if (s.exc_req) begin
          epc_r      <= in_delay ? (s.pc_current - 32'd4) : s.pc_current;
          mdu_cnt    <= '0;
          pend_valid <= 1'b0;
          state      <= RUN;
        end else begin
          if (mdu_cnt != '0)
            mdu_cnt <= mdu_cnt - CNT_W'(1);
          else if (s.mdu_start && (s.mdu_cycles != '0))
            mdu_cnt <= s.mdu_cycles - CNT_W'(1);

          if (stall) begin
            state <= in_delay ? state : STALL;
            if (latch_pend) begin
              pend_valid  <= 1'b1;
              pend_target <= redir_tgt;
              pend_prio   <= redir_prio;
            end
          end else begin
            pend_valid <= 1'b0;
            state      <= RUN;
`ifdef DELAY_SLOT_EN
            if (!in_delay && redir && !s.eret_req) begin
              pend_target <= redir_tgt;
              state       <= DELAY;
            end
`endif
          end
        end
      end
    end
  end

  assign s.pc_next   = nxt;
  assign s.pc_enable = en_r;
  assign s.pc_pause  = pause;
  assign s.epc       = epc_r;
  assign s.flush     = fl;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer with a behavioural pc_register closing the PC loop.
module tb_pc_sequencer;
  localparam logic [31:0] RST = 32'h00400000;
  localparam logic [31:0] EXV = 32'h00400004;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pc_sequencer_if #(.CNT_W(6)) dif();
  pc_sequencer #(.RESET_PC(RST), .EXC_VECTOR(EXV), .CNT_W(6)) dut (.clock(clock), .reset(reset), .s(dif));

  // pc_register: loads pc_next when enabled and not paused
  always_ff @(posedge clock or posedge reset)
    if (reset) dif.pc_current <= RST;
    else if (dif.pc_enable && !dif.pc_pause) dif.pc_current <= dif.pc_next;

  typedef struct packed {
    logic hz; logic ms; logic [5:0] mc; logic br; logic [31:0] bt;
    logic jv; logic [31:0] jt; logic ex; logic er;
  } stim_t;
  typedef struct packed {
    logic [31:0] nxt; logic [31:0] pcur; logic [31:0] epc;
    logic pause; logic flush; logic cn; logic cf;
  } exp_t;

  stim_t sq[$];
  exp_t  eq[$];
  exp_t  sb[$];
  int n_chk = 0;
  int n_fail = 0;

  function automatic stim_t s_hz();  stim_t v = '0; v.hz = 1'b1; return v; endfunction
  function automatic stim_t s_exc(); stim_t v = '0; v.ex = 1'b1; return v; endfunction
  function automatic stim_t s_eret(); stim_t v = '0; v.er = 1'b1; return v; endfunction
  function automatic stim_t s_mdu(input logic [5:0] c); stim_t v = '0; v.ms = 1'b1; v.mc = c; return v; endfunction
  function automatic stim_t s_br(input logic [31:0] t); stim_t v = '0; v.br = 1'b1; v.bt = t; return v; endfunction
  function automatic stim_t s_jv(input logic [31:0] t); stim_t v = '0; v.jv = 1'b1; v.jt = t; return v; endfunction

  function automatic exp_t ex(input logic [31:0] n, input logic p, input logic f, input logic [31:0] pc, input logic [31:0] ep);
    exp_t e; e.nxt = n; e.pause = p; e.flush = f; e.pcur = pc; e.epc = ep; e.cn = 1'b1; e.cf = 1'b1; return e;
  endfunction
  function automatic exp_t hold(input logic [31:0] pc, input logic [31:0] ep);
    exp_t e = ex(32'h0, 1'b1, 1'b0, pc, ep); e.cn = 1'b0; e.cf = 1'b0; return e;
  endfunction
  function automatic exp_t nf(input logic [31:0] n, input logic [31:0] pc, input logic [31:0] ep);
    exp_t e = ex(n, 1'b0, 1'b0, pc, ep); e.cf = 1'b0; return e;
  endfunction

  task automatic row(input stim_t s, input exp_t e); sq.push_back(s); eq.push_back(e); endtask

  task automatic drive(input stim_t v);
    dif.hazard_stall = v.hz; dif.mdu_start = v.ms; dif.mdu_cycles = v.mc;
    dif.branch_taken = v.br; dif.branch_target = v.bt;
    dif.jump_valid = v.jv; dif.jump_target = v.jt;
    dif.exc_req = v.ex; dif.eret_req = v.er;
  endtask

  task automatic do_reset();
    drive('0); reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    exp_t e; int k = 0;
    drive('0); reset = 1'b1;
    @(negedge clock);
    n_chk++;
    if (dif.pc_next !== RST || dif.pc_enable !== 1'b0 || dif.pc_pause !== 1'b0 || dif.flush !== 1'b0 || dif.epc !== RST) begin
      n_fail++;
      $display("FAIL reset_values: got nxt=%h en=%b pause=%b flush=%b epc=%h; want nxt=%h en=0 pause=0 flush=0 epc=%h",
               dif.pc_next, dif.pc_enable, dif.pc_pause, dif.flush, dif.epc, RST, RST);
    end
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    n_chk++;
    if (dif.pc_enable !== 1'b0 || dif.pc_next !== RST || dif.pc_current !== RST) begin
      n_fail++;
      $display("FAIL reset_release: got en=%b nxt=%h pc=%h; want en=0 nxt=%h pc=%h", dif.pc_enable, dif.pc_next, dif.pc_current, RST, RST);
    end
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) row('0, ex(RST + 32'(4*(i+1)), 1'b0, 1'b0, RST + 32'(4*i), RST));
    while (sq.size() != 0) begin
      drive(sq.pop_front()); sb.push_back(eq.pop_front());
      @(negedge clock);
      e = sb.pop_front(); n_chk++;
      if (dif.pc_current !== e.pcur || dif.epc !== e.epc || dif.pc_pause !== e.pause || dif.pc_enable !== 1'b1 ||
          (e.cn && dif.pc_next !== e.nxt) || (e.cf && dif.flush !== e.flush)) begin
        n_fail++;
        $display("FAIL reset_seq row %0d: got nxt=%h pause=%b flush=%b pc=%h epc=%h en=%b; want nxt=%h pause=%b flush=%b pc=%h epc=%h",
                 k, dif.pc_next, dif.pc_pause, dif.flush, dif.pc_current, dif.epc, dif.pc_enable, e.nxt, e.pause, e.flush, e.pcur, e.epc);
      end
      k++; @(posedge clock); #1;
    end
  endtask

  task automatic test_mdu();
    exp_t e; int k = 0;
    do_reset();
    for (int i = 0; i < 4; i++) row('0, ex(RST + 32'(4*(i+1)), 1'b0, 1'b0, RST + 32'(4*i), RST));
    row(s_mdu(6'd3), hold(32'h00400010, RST));
    row(s_mdu(6'd5), hold(32'h00400010, RST));
    row('0,          hold(32'h00400010, RST));
    row('0,          ex(32'h00400014, 1'b0, 1'b0, 32'h00400010, RST));
    row(s_mdu(6'd0), ex(32'h00400018, 1'b0, 1'b0, 32'h00400014, RST));
    row('0,          ex(32'h0040001C, 1'b0, 1'b0, 32'h00400018, RST));
    while (sq.size() != 0) begin
      drive(sq.pop_front()); sb.push_back(eq.pop_front());
      @(negedge clock);
      e = sb.pop_front(); n_chk++;
      if (dif.pc_current !== e.pcur || dif.epc !== e.epc || dif.pc_pause !== e.pause || dif.pc_enable !== 1'b1 ||
          (e.cn && dif.pc_next !== e.nxt) || (e.cf && dif.flush !== e.flush)) begin
        n_fail++;
        $display("FAIL mdu row %0d: got nxt=%h pause=%b flush=%b pc=%h epc=%h en=%b; want nxt=%h pause=%b flush=%b pc=%h epc=%h",
                 k, dif.pc_next, dif.pc_pause, dif.flush, dif.pc_current, dif.epc, dif.pc_enable, e.nxt, e.pause, e.flush, e.pcur, e.epc);
      end
      k++; @(posedge clock); #1;
    end
  endtask

  task automatic test_hazard_redirect();
    exp_t e; int k = 0;
    do_reset();
    row(s_hz(),                         hold(RST, RST));
    row(s_hz() | s_br(32'h00400100),    hold(RST, RST));
    row(s_hz() | s_jv(32'h00400300),    hold(RST, RST));
    row('0,                             nf(32'h00400300, RST, RST));
    row('0,                             ex(32'h00400304, 1'b0, 1'b0, 32'h00400300, RST));
    row(s_hz() | s_jv(32'h00400500),    hold(32'h00400304, RST));
    row(s_hz() | s_br(32'h00400600),    hold(32'h00400304, RST));
    row('0,                             nf(32'h00400500, 32'h00400304, RST));
    row('0,                             ex(32'h00400504, 1'b0, 1'b0, 32'h00400500, RST));
    row(s_hz() | s_br(32'h00400100),    hold(32'h00400504, RST));
    row('0,                             nf(32'h00400100, 32'h00400504, RST));
    row('0,                             ex(32'h00400104, 1'b0, 1'b0, 32'h00400100, RST));
    while (sq.size() != 0) begin
      drive(sq.pop_front()); sb.push_back(eq.pop_front());
      @(negedge clock);
      e = sb.pop_front(); n_chk++;
      if (dif.pc_current !== e.pcur || dif.epc !== e.epc || dif.pc_pause !== e.pause || dif.pc_enable !== 1'b1 ||
          (e.cn && dif.pc_next !== e.nxt) || (e.cf && dif.flush !== e.flush)) begin
        n_fail++;
        $display("FAIL hazard_redirect row %0d: got nxt=%h pause=%b flush=%b pc=%h epc=%h en=%b; want nxt=%h pause=%b flush=%b pc=%h epc=%h",
                 k, dif.pc_next, dif.pc_pause, dif.flush, dif.pc_current, dif.epc, dif.pc_enable, e.nxt, e.pause, e.flush, e.pcur, e.epc);
      end
      k++; @(posedge clock); #1;
    end
  endtask

  task automatic test_exc();
    exp_t e; int k = 0;
    do_reset();
    for (int i = 0; i < 8; i++) row('0, ex(RST + 32'(4*(i+1)), 1'b0, 1'b0, RST + 32'(4*i), RST));
    row(s_mdu(6'd4),                 hold(32'h00400020, RST));
    row(s_exc(),                     ex(EXV, 1'b0, 1'b1, 32'h00400020, RST));
    row('0,                          ex(32'h00400008, 1'b0, 1'b0, EXV, 32'h00400020));
    row(s_hz() | s_br(32'h00400900), hold(32'h00400008, 32'h00400020));
    row(s_hz() | s_exc(),            ex(EXV, 1'b0, 1'b1, 32'h00400008, 32'h00400020));
    row('0,                          ex(32'h00400008, 1'b0, 1'b0, EXV, 32'h00400008));
    while (sq.size() != 0) begin
      drive(sq.pop_front()); sb.push_back(eq.pop_front());
      @(negedge clock);
      e = sb.pop_front(); n_chk++;
      if (dif.pc_current !== e.pcur || dif.epc !== e.epc || dif.pc_pause !== e.pause || dif.pc_enable !== 1'b1 ||
          (e.cn && dif.pc_next !== e.nxt) || (e.cf && dif.flush !== e.flush)) begin
        n_fail++;
        $display("FAIL exc row %0d: got nxt=%h pause=%b flush=%b pc=%h epc=%h en=%b; want nxt=%h pause=%b flush=%b pc=%h epc=%h",
                 k, dif.pc_next, dif.pc_pause, dif.flush, dif.pc_current, dif.epc, dif.pc_enable, e.nxt, e.pause, e.flush, e.pcur, e.epc);
      end
      k++; @(posedge clock); #1;
    end
  endtask

`ifndef DELAY_SLOT_EN
  task automatic test_jump_eret();
    exp_t e; int k = 0;
    do_reset();
    for (int i = 0; i < 3; i++) row('0, ex(RST + 32'(4*(i+1)), 1'b0, 1'b0, RST + 32'(4*i), RST));
    row(s_exc(),                                ex(EXV, 1'b0, 1'b1, 32'h0040000C, RST));
    row('0,                                     ex(32'h00400008, 1'b0, 1'b0, EXV, 32'h0040000C));
    row(s_jv(32'h00400800) | s_br(32'h00400900), ex(32'h00400800, 1'b0, 1'b1, 32'h00400008, 32'h0040000C));
    row('0,                                     ex(32'h00400804, 1'b0, 1'b0, 32'h00400800, 32'h0040000C));
    row(s_eret(),                               ex(32'h0040000C, 1'b0, 1'b1, 32'h00400804, 32'h0040000C));
    row('0,                                     ex(32'h00400010, 1'b0, 1'b0, 32'h0040000C, 32'h0040000C));
    row(s_exc() | s_eret(),                     ex(EXV, 1'b0, 1'b1, 32'h00400010, 32'h0040000C));
    row('0,                                     ex(32'h00400008, 1'b0, 1'b0, EXV, 32'h00400010));
    row(s_jv(32'hFFFFFFFC),                     ex(32'hFFFFFFFC, 1'b0, 1'b1, 32'h00400008, 32'h00400010));
    row('0,                                     ex(32'h00000000, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h00400010));
    row('0,                                     ex(32'h00000004, 1'b0, 1'b0, 32'h00000000, 32'h00400010));
    while (sq.size() != 0) begin
      drive(sq.pop_front()); sb.push_back(eq.pop_front());
      @(negedge clock);
      e = sb.pop_front(); n_chk++;
      if (dif.pc_current !== e.pcur || dif.epc !== e.epc || dif.pc_pause !== e.pause || dif.pc_enable !== 1'b1 ||
          (e.cn && dif.pc_next !== e.nxt) || (e.cf && dif.flush !== e.flush)) begin
        n_fail++;
        $display("FAIL jump_eret row %0d: got nxt=%h pause=%b flush=%b pc=%h epc=%h en=%b; want nxt=%h pause=%b flush=%b pc=%h epc=%h",
                 k, dif.pc_next, dif.pc_pause, dif.flush, dif.pc_current, dif.epc, dif.pc_enable, e.nxt, e.pause, e.flush, e.pcur, e.epc);
      end
      k++; @(posedge clock); #1;
    end
  endtask
`else
  task automatic test_delay();
    exp_t e; int k = 0;
    do_reset();
    for (int i = 0; i < 16; i++) row('0, ex(RST + 32'(4*(i+1)), 1'b0, 1'b0, RST + 32'(4*i), RST));
    row(s_jv(32'h00400200), ex(32'h00400044, 1'b0, 1'b0, 32'h00400040, RST));
    row(s_jv(32'h00400700), ex(32'h00400200, 1'b0, 1'b0, 32'h00400044, RST));
    row('0,                 ex(32'h00400204, 1'b0, 1'b0, 32'h00400200, RST));
    row(s_br(32'h00400400), ex(32'h00400208, 1'b0, 1'b0, 32'h00400204, RST));
    row(s_hz(),             hold(32'h00400208, RST));
    row('0,                 ex(32'h00400400, 1'b0, 1'b0, 32'h00400208, RST));
    row(s_jv(32'hFFFFFFFC), ex(32'h00400404, 1'b0, 1'b0, 32'h00400400, RST));
    row(s_exc(),            ex(EXV, 1'b0, 1'b1, 32'h00400404, RST));
    row('0,                 ex(32'h00400008, 1'b0, 1'b0, EXV, 32'h00400400));
    row(s_jv(32'hFFFFFFFC), ex(32'h0040000C, 1'b0, 1'b0, 32'h00400008, 32'h00400400));
    row('0,                 ex(32'hFFFFFFFC, 1'b0, 1'b0, 32'h0040000C, 32'h00400400));
    row('0,                 ex(32'h00000000, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h00400400));
    row('0,                 ex(32'h00000004, 1'b0, 1'b0, 32'h00000000, 32'h00400400));
    while (sq.size() != 0) begin
      drive(sq.pop_front()); sb.push_back(eq.pop_front());
      @(negedge clock);
      e = sb.pop_front(); n_chk++;
      if (dif.pc_current !== e.pcur || dif.epc !== e.epc || dif.pc_pause !== e.pause || dif.pc_enable !== 1'b1 ||
          (e.cn && dif.pc_next !== e.nxt) || (e.cf && dif.flush !== e.flush)) begin
        n_fail++;
        $display("FAIL delay row %0d: got nxt=%h pause=%b flush=%b pc=%h epc=%h en=%b; want nxt=%h pause=%b flush=%b pc=%h epc=%h",
                 k, dif.pc_next, dif.pc_pause, dif.flush, dif.pc_current, dif.epc, dif.pc_enable, e.nxt, e.pause, e.flush, e.pcur, e.epc);
      end
      k++; @(posedge clock); #1;
    end
  endtask
`endif

  task automatic test_reset_midstall();
    do_reset();
    drive('0);        @(posedge clock); #1;
    drive(s_exc());   @(posedge clock); #1;
    drive(s_mdu(6'd10));
    @(negedge clock);
    n_chk++;
    if (dif.pc_pause !== 1'b1 || dif.epc !== 32'h00400004) begin
      n_fail++;
      $display("FAIL midstall_setup: got pause=%b epc=%h; want pause=1 epc=00400004", dif.pc_pause, dif.epc);
    end
    @(posedge clock); #1 drive('0);
    @(negedge clock);
    reset = 1'b1; #1;
    n_chk++;
    if (dif.pc_pause !== 1'b0 || dif.pc_next !== RST || dif.pc_enable !== 1'b0 || dif.epc !== RST || dif.flush !== 1'b0) begin
      n_fail++;
      $display("FAIL midstall_reset: got pause=%b nxt=%h en=%b epc=%h flush=%b; want pause=0 nxt=%h en=0 epc=%h flush=0",
               dif.pc_pause, dif.pc_next, dif.pc_enable, dif.epc, dif.flush, RST, RST);
    end
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    n_chk++;
    if (dif.pc_pause !== 1'b0 || dif.pc_next !== (RST + 32'd4) || dif.pc_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL midstall_after: got pause=%b nxt=%h en=%b; want pause=0 nxt=%h en=1", dif.pc_pause, dif.pc_next, dif.pc_enable, RST + 32'd4);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mdu();
    test_hazard_redirect();
    test_exc();
`ifndef DELAY_SLOT_EN
    test_jump_eret();
`else
    test_delay();
`endif
    test_reset_midstall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
